haraka_s_sponge_ctrl: RTL and testbench

- Sponge controller for the Haraka-S hash; acts as initiator for the Haraka-512 permutation wrapper.
- Accepts a message stream as 256-bit rate blocks and applies byte padding.
- Absorbs each block into a 512-bit state register and sequences one permutation per block through a start/done handshake.
- Squeezes OUT_BLOCKS 256-bit output blocks, with a permutation between consecutive blocks.

---
 rtl/haraka_s_sponge_ctrl.sv | 163 ++++++++++++++++
 tb/tb_haraka_s_sponge_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/haraka_s_sponge_ctrl.sv
// rtl/haraka_s_sponge_ctrl.sv - Haraka-S sponge: absorb 256-bit rate blocks, drive Haraka-512 permutation, squeeze OUT_BLOCKS blocks
// Optional byte padding (and the trailing pad-only block for full last blocks) is built when HARAKA_S_BYTE_PAD_EN is defined.
module haraka_s_sponge_ctrl #(
   parameter int OUT_BLOCKS = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [255:0] in_data,
   input  logic         in_last,
   input  logic [5:0]   in_nbytes,
   output logic         perm_start,
   output logic [511:0] perm_state_o,
   input  logic         perm_done,
   input  logic [511:0] perm_state_i,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] out_data,
   output logic         out_last
);

   typedef enum logic [2:0] {
      IDLE,
      ABSORB,
      PERM,
      PAD,
      SQUEEZE,
      SQ_PERM
   } fsm_t;

   localparam logic [3:0] LAST_IDX = 4'(OUT_BLOCKS - 1);

   fsm_t         fsm;
   logic [511:0] state_q;
   logic         last_q;
   logic         pad_owed_q;
   logic [3:0]   sq_cnt;
   logic [255:0] blk_in;
   logic         pad_need;

`ifdef HARAKA_S_BYTE_PAD_EN
   localparam logic [255:0] PAD_ONLY = {8'h1F, 240'd0, 8'h80};

   logic [5:0] n_eff;
   assign n_eff    = (in_nbytes > 6'd32) ? 6'd32 : in_nbytes;
   assign pad_need = in_last && (n_eff == 6'd32);

   // Bytes past the message end are zeroed, so the 0x1F marker is a plain store.
   always_comb begin
      blk_in = in_data;
      if (in_last) begin
         for (int k = 0; k < 32; k++) begin
            if (6'(k) >= n_eff)
               blk_in[255-8*k -: 8] = 8'h00;
            if (6'(k) == n_eff)
               blk_in[255-8*k -: 8] = 8'h1F;
         end
         if (n_eff != 6'd32)
            blk_in[7:0] = blk_in[7:0] ^ 8'h80;
      end
   end
`else
   logic unused_nbytes;
   assign unused_nbytes = ^in_nbytes;
   assign blk_in        = in_data;
   assign pad_need      = 1'b0;
`endif

   assign perm_state_o = state_q;
   assign out_data     = state_q[511:256];

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm        <= IDLE;
         state_q    <= '0;
         last_q     <= 1'b0;
         pad_owed_q <= 1'b0;
         sq_cnt     <= 4'd0;
         in_ready   <= 1'b0;
         perm_start <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
      end else begin
         case (fsm)
            IDLE: begin
               state_q    <= '0;
               last_q     <= 1'b0;
               pad_owed_q <= 1'b0;
               in_ready   <= 1'b1;
               fsm        <= ABSORB;
            end

            ABSORB: begin
               if (in_valid && in_ready) begin
                  state_q[511:256] <= state_q[511:256] ^ blk_in;
                  last_q           <= in_last;
                  pad_owed_q       <= pad_need;
                  in_ready         <= 1'b0;
                  perm_start       <= 1'b1;
                  fsm              <= PERM;
               end
            end

            PERM: begin
               perm_start <= 1'b0;
               if (perm_done) begin
                  state_q <= perm_state_i;
                  if (pad_owed_q) begin
                     fsm <= PAD;
                  end else if (last_q) begin
                     sq_cnt    <= 4'd0;
                     out_valid <= 1'b1;
                     out_last  <= (LAST_IDX == 4'd0);
                     fsm       <= SQUEEZE;
                  end else begin
                     in_ready <= 1'b1;
                     fsm      <= ABSORB;
                  end
               end
            end

            PAD: begin
`ifdef HARAKA_S_BYTE_PAD_EN
               state_q[511:256] <= state_q[511:256] ^ PAD_ONLY;
               pad_owed_q       <= 1'b0;
               perm_start       <= 1'b1;
               fsm              <= PERM;
`else
               fsm <= IDLE;
`endif
            end

            SQUEEZE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (sq_cnt == LAST_IDX) begin
                     fsm <= IDLE;
                  end else begin
                     sq_cnt     <= sq_cnt + 4'd1;
                     perm_start <= 1'b1;
                     fsm        <= SQ_PERM;
                  end
               end
            end

            SQ_PERM: begin
               perm_start <= 1'b0;
               if (perm_done) begin
                  state_q   <= perm_state_i;
                  out_valid <= 1'b1;
                  out_last  <= (sq_cnt == LAST_IDX);
                  fsm       <= SQUEEZE;
               end
            end

            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_haraka_s_sponge_ctrl.sv
// tb/tb_haraka_s_sponge_ctrl.sv - directed vector bench for haraka_s_sponge_ctrl with a delayed permutation responder
module tb_haraka_s_sponge_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] in_data;
   logic         in_last;
   logic [5:0]   in_nbytes;
   logic         perm_start;
   logic [511:0] perm_state_o;
   logic         perm_done;
   logic [511:0] perm_state_i;
   logic         out_valid;
   logic         out_ready;
   logic [255:0] out_data;
   logic         out_last;

   always #5 clk = ~clk;

   haraka_s_sponge_ctrl #(.OUT_BLOCKS(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .in_nbytes    (in_nbytes),
      .perm_start   (perm_start),
      .perm_state_o (perm_state_o),
      .perm_done    (perm_done),
      .perm_state_i (perm_state_i),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_last     (out_last)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   // Permutation responder and protocol monitor, sampled 2 units after the falling edge.
   logic         resp_rot   = 1'b0;
   int           resp_delay = 0;
   logic         busy       = 1'b0;
   int           cnt        = 0;
   logic [511:0] cap;
   int           start_cnt  = 0;
   logic [511:0] start_log[$];
   logic         ov_seen    = 1'b0;
   int           starts_at_ov = 0;
   int           hold_viol  = 0;
   int           hold_samples = 0;
   logic         prev_stall = 1'b0;
   logic [256:0] prev_out;

   initial begin
      perm_done    = 1'b0;
      perm_state_i = '0;
      forever begin
         @(negedge clk);
         #2;
         perm_done = 1'b0;
         if (prev_stall) begin
            hold_samples++;
            if (!out_valid || {out_last, out_data} !== prev_out) hold_viol++;
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {out_last, out_data};
         if (out_valid && !ov_seen) begin
            ov_seen      = 1'b1;
            starts_at_ov = start_cnt;
         end
         if (perm_start) begin
            start_cnt++;
            start_log.push_back(perm_state_o);
            busy = 1'b1;
            cnt  = resp_delay;
            cap  = perm_state_o;
         end
         if (busy) begin
            if (cnt == 0) begin
               perm_done    = 1'b1;
               perm_state_i = resp_rot ? {cap[510:0], cap[511]} : cap;
               busy         = 1'b0;
            end else begin
               cnt--;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic send(input logic [255:0] d, input logic last, input logic [5:0] n);
      int w = 0;
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("in_ready_wait", 512'(in_ready), 512'(1));
      in_valid  = 1'b1;
      in_data   = d;
      in_last   = last;
      in_nbytes = n;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("start_latency", 512'(perm_start), 512'(1));
   endtask

   task automatic collect(input logic toggle, output logic [255:0] first_d,
                          output logic [255:0] last_d, output logic [2:0] lasts, output int hs);
      hs      = 0;
      lasts   = 3'b000;
      first_d = '0;
      last_d  = '0;
      out_ready = !toggle;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (toggle) out_ready = ~out_ready;
         if (out_valid && out_ready) begin
            if (hs == 0) first_d = out_data;
            last_d    = out_data;
            lasts[hs] = out_last;
            hs++;
         end
         if (hs == 3) begin
            @(negedge clk);
            break;
         end
      end
      out_ready = 1'b0;
   endtask

   typedef struct {
      logic [255:0] data;
      logic [5:0]   n;
      logic         rot;
      int           dly;
      logic [255:0] exp;
      int           pre;
   } vec_t;

   vec_t         tbl[5];
   logic [255:0] fd, ld, exp_multi, empty_d, empty_exp;
   logic [5:0]   empty_n;
   logic [2:0]   lasts;
   int           hs, base;

   initial begin
`ifdef HARAKA_S_BYTE_PAD_EN
      tbl[0] = '{256'd0, 6'd0, 1'b0, 0, {8'h1F, {30{8'h00}}, 8'h80}, 1};
      tbl[1] = '{{32{8'h55}}, 6'd31, 1'b0, 1, {{31{8'h55}}, 8'h9F}, 1};
      tbl[2] = '{{32{8'hAA}}, 6'd5, 1'b0, 3, {{5{8'hAA}}, 8'h1F, {25{8'h00}}, 8'h80}, 1};
      tbl[3] = '{{32{8'h11}}, 6'd40, 1'b0, 0, {8'h0E, {30{8'h11}}, 8'h91}, 2};
      tbl[4] = '{{32{8'h81}}, 6'd32, 1'b1, 2, {8'h38, {29{8'h06}}, 8'h07, 8'h04}, 2};
      exp_multi = {{4{8'h07}}, 8'h1C, {26{8'h03}}, 8'h83};
      empty_d   = 256'd0;
      empty_n   = 6'd0;
`else
      tbl[0] = '{256'd0, 6'd0, 1'b0, 0, 256'd0, 1};
      tbl[1] = '{{32{8'h55}}, 6'd31, 1'b0, 1, {32{8'h55}}, 1};
      tbl[2] = '{{32{8'hAA}}, 6'd5, 1'b0, 3, {32{8'hAA}}, 1};
      tbl[3] = '{{32{8'h11}}, 6'd40, 1'b0, 0, {32{8'h11}}, 1};
      tbl[4] = '{{32{8'h81}}, 6'd32, 1'b1, 2, {{31{8'h03}}, 8'h02}, 1};
      exp_multi = {32{8'h07}};
      empty_d   = {8'h1F, {30{8'h00}}, 8'h80};
      empty_n   = 6'd0;
`endif
      empty_exp = {8'h1F, {30{8'h00}}, 8'h80};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_nbytes = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ctrl", 512'({in_ready, perm_start, out_valid, out_last}), 512'(0));
      chk("reset_state", perm_state_o, 512'd0);
      chk("reset_out_data", 512'(out_data), 512'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("first_in_ready", 512'(in_ready), 512'(1));

      for (int i = 0; i < 5; i++) begin
         resp_rot   = tbl[i].rot;
         resp_delay = tbl[i].dly;
         ov_seen    = 1'b0;
         base       = start_cnt;
         start_log.delete();
         send(tbl[i].data, 1'b1, tbl[i].n);
         collect(1'b0, fd, ld, lasts, hs);
         chk($sformatf("v%0d_out_data", i), 512'(fd), 512'(tbl[i].exp));
         chk($sformatf("v%0d_starts_before_out", i), 512'(starts_at_ov - base), 512'(tbl[i].pre));
         chk($sformatf("v%0d_starts_total", i), 512'(start_cnt - base), 512'(tbl[i].pre + 2));
         chk($sformatf("v%0d_out_last", i), 512'(lasts), 512'(3'b100));
      end
`ifdef HARAKA_S_BYTE_PAD_EN
      chk("n32_pad_perm_rate", (start_log.size() > 1) ? 512'(start_log[1][511:256]) : 512'd0,
          512'({8'h1C, {30{8'h03}}, 8'h82}));
`endif

      // Three-block message, slow permutation, consumer toggling ready.
      resp_rot = 1'b0; resp_delay = 7; ov_seen = 1'b0; base = start_cnt;
      hold_viol = 0; hold_samples = 0;
      send({32{8'h01}}, 1'b0, 6'd0);
      send({32{8'h02}}, 1'b0, 6'd0);
      send({32{8'h04}}, 1'b1, 6'd4);
      collect(1'b1, fd, ld, lasts, hs);
      chk("multi_handshakes", 512'(hs), 512'(3));
      chk("multi_starts", 512'(start_cnt - base), 512'(5));
      chk("multi_out_last", 512'(lasts), 512'(3'b100));
      chk("multi_out_data", 512'(fd), 512'(exp_multi));
      chk("multi_last_data", 512'(ld), 512'(exp_multi));
      chk("multi_hold_stable", 512'({hold_viol == 0, hold_samples > 0}), 512'(2'b11));

      // Reset two cycles after perm_start; the late perm_done must be ignored.
      resp_delay = 5;
      send({32{8'h33}}, 1'b0, 6'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ctrl", 512'({in_ready, perm_start, out_valid, out_last}), 512'(0));
      chk("midrst_state", perm_state_o, 512'd0);
      chk("midrst_out_data", 512'(out_data), 512'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("stray_done_state", perm_state_o, 512'd0);
      chk("stray_done_ready", 512'({in_ready, out_valid}), 512'(2'b10));

      resp_delay = 0; ov_seen = 1'b0; base = start_cnt;
      send(empty_d, 1'b1, empty_n);
      collect(1'b0, fd, ld, lasts, hs);
      chk("post_rst_out_data", 512'(fd), 512'(empty_exp));
      chk("post_rst_out_last", 512'(lasts), 512'(3'b100));
      chk("post_rst_starts", 512'(start_cnt - base), 512'(3));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
